// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types for the rolly FIFO replay controller and its timer.
package bsg_fifo_rolly_pkg;

  typedef enum logic [0:0] {eSend, eRoll} bsg_fifo_rolly_replay_state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned bsg_fifo_rolly_cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_rolly_replay_ctrl_if.sv
// FIFO read port plus link/ack channel between the replay controller and its neighbours.
interface bsg_fifo_rolly_replay_ctrl_if #(parameter int unsigned width_p = 8);

  logic [width_p-1:0] fifo_data_i;
  logic               fifo_v_i;
  logic               fifo_yumi_o;
  logic               fifo_deq_o;
  logic               fifo_roll_o;
  logic [width_p-1:0] link_data_o;
  logic               link_v_o;
  logic               link_ready_i;
  logic               ack_v_i;
  logic               nack_v_i;

  modport master (
    input  fifo_data_i, fifo_v_i, link_ready_i, ack_v_i, nack_v_i,
    output fifo_yumi_o, fifo_deq_o, fifo_roll_o, link_data_o, link_v_o
  );

  modport slave (
    output fifo_data_i, fifo_v_i, link_ready_i, ack_v_i, nack_v_i,
    input  fifo_yumi_o, fifo_deq_o, fifo_roll_o, link_data_o, link_v_o
  );

endinterface

// File: rtl/bsg_fifo_rolly_timer.sv
// Idle timer for the replay controller: flags expiry after timeout_p enabled cycles.
module bsg_fifo_rolly_timer
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int unsigned timeout_p = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned cnt_w_lp = bsg_fifo_rolly_cnt_w(timeout_p - 1);

  logic [cnt_w_lp-1:0] cnt_r;

  assign expired_o = en_i & (cnt_r == cnt_w_lp'(timeout_p - 1));

  // Holds at the terminal count; the roll that follows expiry clears it.
  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i)
      cnt_r <= '0;
    else if (en_i & ~expired_o)
      cnt_r <= cnt_r + cnt_w_lp'(1);
  end

endmodule

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Go-back-N replay controller on the read side of a rolly FIFO.
// Define BSG_FIFO_ROLLY_REPLAY_CTRL_TIMEOUT_EN to add an idle-timeout auto-roll.
module bsg_fifo_rolly_replay_ctrl
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int unsigned width_p      = 8,
  parameter int unsigned lg_size_p    = 3,
  parameter int unsigned window_p     = 1 << lg_size_p,
  parameter int unsigned timeout_p    = 256,
  parameter int unsigned roll_cnt_w_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_fifo_rolly_replay_ctrl_if.master io,
  output logic [lg_size_p:0]      outstanding_o,
  output logic [roll_cnt_w_p-1:0] roll_cnt_o,
  output logic                    err_o
);

  localparam int unsigned cnt_w_lp = lg_size_p + 1;

  bsg_fifo_rolly_replay_state_e state_r, state_n;
  logic [cnt_w_lp-1:0]     out_r, out_n;
  logic [roll_cnt_w_p-1:0] roll_cnt_r, roll_cnt_n;
  logic                    err_r, err_n;
  logic                    link_v, yumi, deq, roll, roll_go;
  logic                    has_out, timeout_fire;
  logic [width_p-1:0]      head_data;

  assign has_out   = (out_r != '0);
  assign head_data = io.fifo_data_i;

`ifdef BSG_FIFO_ROLLY_REPLAY_CTRL_TIMEOUT_EN
  logic timer_expired;

  bsg_fifo_rolly_timer #(.timeout_p(timeout_p)) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   ((state_r == eRoll) | io.ack_v_i | ~has_out),
    .en_i      ((state_r == eSend) & has_out),
    .expired_o (timer_expired)
  );

  assign timeout_fire = timer_expired & ~io.ack_v_i;
`else
  assign timeout_fire = 1'b0;
`endif

  // Next-state and strobe decode; nack outranks a same-cycle ack.
  always_comb begin
    state_n    = state_r;
    out_n      = out_r;
    roll_cnt_n = roll_cnt_r;
    err_n      = err_r;
    link_v     = 1'b0;
    yumi       = 1'b0;
    deq        = 1'b0;
    roll       = 1'b0;
    roll_go    = 1'b0;
    unique case (state_r)
      eSend: begin
        link_v = io.fifo_v_i & (out_r < cnt_w_lp'(window_p));
        yumi   = link_v & io.link_ready_i;
        if (io.nack_v_i) begin
          if (has_out | yumi) roll_go = 1'b1;
          else                err_n   = 1'b1;
        end else if (io.ack_v_i) begin
          if (has_out) deq   = 1'b1;
          else         err_n = 1'b1;
        end
        if (timeout_fire) roll_go = 1'b1;
        out_n = out_r + cnt_w_lp'(yumi) - cnt_w_lp'(deq);
        if (roll_go) state_n = eRoll;
      end
      eRoll: begin
        roll  = 1'b1;
        out_n = '0;
        if (roll_cnt_r != '1) roll_cnt_n = roll_cnt_r + roll_cnt_w_p'(1);
        if (io.ack_v_i | io.nack_v_i) err_n = 1'b1;
        state_n = eSend;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eSend;
      out_r      <= '0;
      roll_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      out_r      <= out_n;
      roll_cnt_r <= roll_cnt_n;
      err_r      <= err_n;
    end
  end

  // Strobes are held low while reset is asserted.
  assign io.link_v_o    = link_v & ~reset_i;
  assign io.fifo_yumi_o = yumi & ~reset_i;
  assign io.fifo_deq_o  = deq & ~reset_i;
  assign io.fifo_roll_o = roll & ~reset_i;
  assign io.link_data_o = head_data;

  assign outstanding_o = out_r;
  assign roll_cnt_o    = roll_cnt_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Directed bench for the rolly FIFO replay controller (window 4 and window 2 instances).
module tb_bsg_fifo_rolly_replay_ctrl;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  bsg_fifo_rolly_replay_ctrl_if #(.width_p(8)) ifa ();
  bsg_fifo_rolly_replay_ctrl_if #(.width_p(8)) ifb ();

  logic [2:0]  out_a, out_b;
  logic [15:0] rc_a, rc_b;
  logic        err_a, err_b;

  bsg_fifo_rolly_replay_ctrl #(
    .width_p(8), .lg_size_p(2), .window_p(4), .timeout_p(8), .roll_cnt_w_p(16)
  ) u_dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .io(ifa.master),
    .outstanding_o(out_a), .roll_cnt_o(rc_a), .err_o(err_a)
  );

  bsg_fifo_rolly_replay_ctrl #(
    .width_p(8), .lg_size_p(2), .window_p(2), .timeout_p(8), .roll_cnt_w_p(16)
  ) u_dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .io(ifb.master),
    .outstanding_o(out_b), .roll_cnt_o(rc_b), .err_o(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on instance A: drive after the falling edge, settle, then the caller checks.
  task automatic cyc_a(input logic rst, input logic v, input logic [7:0] d,
                       input logic rdy, input logic ack, input logic nack);
    @(negedge clk_i);
    reset_i          = rst;
    ifa.fifo_v_i     = v;
    ifa.fifo_data_i  = d;
    ifa.link_ready_i = rdy;
    ifa.ack_v_i      = ack;
    ifa.nack_v_i     = nack;
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic [7:0] d, input logic rdy, input logic ack);
    @(negedge clk_i);
    reset_i          = 1'b0;
    ifb.fifo_v_i     = v;
    ifb.fifo_data_i  = d;
    ifb.link_ready_i = rdy;
    ifb.ack_v_i      = ack;
    ifb.nack_v_i     = 1'b0;
    #1;
  endtask

  initial begin
    ifb.fifo_v_i = 1'b0; ifb.fifo_data_i = '0; ifb.link_ready_i = 1'b0;
    ifb.ack_v_i = 1'b0;  ifb.nack_v_i = 1'b0;

    // Reset state
    cyc_a(1, 0, 8'h00, 0, 0, 0);
    cyc_a(1, 0, 8'h00, 0, 0, 0);
    chk("rst_out", 32'(out_a), 0);
    chk("rst_rc", 32'(rc_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_roll", 32'(ifa.fifo_roll_o), 0);
    chk("rst_deq", 32'(ifa.fifo_deq_o), 0);
    chk("rst_out_b", 32'(out_b), 0);

    // Four items, each acked while the next is sent
    cyc_a(0, 1, 8'hA0, 1, 0, 0);
    chk("t1_v0", 32'(ifa.link_v_o), 1);
    chk("t1_d0", 32'(ifa.link_data_o), 32'hA0);
    chk("t1_y0", 32'(ifa.fifo_yumi_o), 1);
    chk("t1_q0", 32'(ifa.fifo_deq_o), 0);
    cyc_a(0, 1, 8'hA1, 1, 1, 0);
    chk("t1_y1", 32'(ifa.fifo_yumi_o), 1);
    chk("t1_q1", 32'(ifa.fifo_deq_o), 1);
    chk("t1_o1", 32'(out_a), 1);
    cyc_a(0, 1, 8'hA2, 1, 1, 0);
    chk("t1_y2", 32'(ifa.fifo_yumi_o), 1);
    chk("t1_q2", 32'(ifa.fifo_deq_o), 1);
    chk("t1_o2", 32'(out_a), 1);
    cyc_a(0, 1, 8'hA3, 1, 1, 0);
    chk("t1_y3", 32'(ifa.fifo_yumi_o), 1);
    chk("t1_q3", 32'(ifa.fifo_deq_o), 1);
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t1_y4", 32'(ifa.fifo_yumi_o), 0);
    chk("t1_q4", 32'(ifa.fifo_deq_o), 1);
    chk("t1_o4", 32'(out_a), 1);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t1_out", 32'(out_a), 0);
    chk("t1_rc", 32'(rc_a), 0);
    chk("t1_err", 32'(err_a), 0);

    // Three items, nack with a simultaneous ack, replay and commit
    cyc_a(0, 1, 8'hB0, 1, 0, 0);
    chk("t3_y0", 32'(ifa.fifo_yumi_o), 1);
    cyc_a(0, 1, 8'hB1, 1, 0, 0);
    chk("t3_o1", 32'(out_a), 1);
    cyc_a(0, 1, 8'hB2, 1, 0, 0);
    chk("t3_o2", 32'(out_a), 2);
    chk("t3_y2", 32'(ifa.fifo_yumi_o), 1);
    cyc_a(0, 0, 8'h00, 1, 1, 1);
    chk("t3_o3", 32'(out_a), 3);
    chk("t3_nack_deq", 32'(ifa.fifo_deq_o), 0);
    chk("t3_nack_roll", 32'(ifa.fifo_roll_o), 0);
    cyc_a(0, 1, 8'hB0, 1, 0, 0);
    chk("t3_roll", 32'(ifa.fifo_roll_o), 1);
    chk("t3_roll_v", 32'(ifa.link_v_o), 0);
    chk("t3_roll_y", 32'(ifa.fifo_yumi_o), 0);
    chk("t3_roll_q", 32'(ifa.fifo_deq_o), 0);
    cyc_a(0, 1, 8'hB0, 1, 0, 0);
    chk("t3_out0", 32'(out_a), 0);
    chk("t3_rc", 32'(rc_a), 1);
    chk("t3_roll_off", 32'(ifa.fifo_roll_o), 0);
    chk("t3_rd0", 32'(ifa.link_data_o), 32'hB0);
    chk("t3_ry0", 32'(ifa.fifo_yumi_o), 1);
    cyc_a(0, 1, 8'hB1, 1, 1, 0);
    chk("t3_rd1", 32'(ifa.link_data_o), 32'hB1);
    chk("t3_q1", 32'(ifa.fifo_deq_o), 1);
    cyc_a(0, 1, 8'hB2, 1, 1, 0);
    chk("t3_q2", 32'(ifa.fifo_deq_o), 1);
    chk("t3_ro2", 32'(out_a), 1);
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t3_q3", 32'(ifa.fifo_deq_o), 1);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t3_end_out", 32'(out_a), 0);
    chk("t3_end_err", 32'(err_a), 0);

    // Ack during eRoll is an error; ack at zero outstanding keeps it set
    cyc_a(0, 1, 8'hD0, 1, 0, 0);
    cyc_a(0, 0, 8'h00, 1, 0, 1);
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t4_roll", 32'(ifa.fifo_roll_o), 1);
    chk("t4_roll_deq", 32'(ifa.fifo_deq_o), 0);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t4_err_roll", 32'(err_a), 1);
    chk("t4_rc", 32'(rc_a), 2);
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t4_ack0_deq", 32'(ifa.fifo_deq_o), 0);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t4_sticky", 32'(err_a), 1);

    // Reset while rolling with three outstanding
    cyc_a(1, 0, 8'h00, 0, 0, 0);
    cyc_a(0, 1, 8'hE0, 1, 0, 0);
    cyc_a(0, 1, 8'hE1, 1, 0, 0);
    cyc_a(0, 1, 8'hE2, 1, 0, 0);
    cyc_a(0, 0, 8'h00, 1, 0, 1);
    chk("t6_o3", 32'(out_a), 3);
    cyc_a(1, 0, 8'h00, 1, 0, 0);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t6_out", 32'(out_a), 0);
    chk("t6_rc", 32'(rc_a), 0);
    chk("t6_err", 32'(err_a), 0);
    chk("t6_roll", 32'(ifa.fifo_roll_o), 0);

    // Ack at zero outstanding sets err; so does a lone nack
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t4_ack0_q", 32'(ifa.fifo_deq_o), 0);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t4_ack0_err", 32'(err_a), 1);
    cyc_a(1, 0, 8'h00, 1, 0, 0);
    cyc_a(0, 0, 8'h00, 1, 0, 1);
    chk("t4_nack0_clr", 32'(err_a), 0);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t4_nack0_err", 32'(err_a), 1);
    chk("t4_nack0_roll", 32'(ifa.fifo_roll_o), 0);
    chk("t4_nack0_rc", 32'(rc_a), 0);
    cyc_a(1, 0, 8'h00, 0, 0, 0);
    cyc_a(0, 0, 8'h00, 0, 0, 0);

    // Window of two on instance B
    cyc_b(1, 8'hC0, 1, 0);
    chk("t2_y0", 32'(ifb.fifo_yumi_o), 1);
    cyc_b(1, 8'hC1, 1, 0);
    chk("t2_y1", 32'(ifb.fifo_yumi_o), 1);
    chk("t2_o1", 32'(out_b), 1);
    cyc_b(1, 8'hC2, 1, 0);
    chk("t2_o2", 32'(out_b), 2);
    chk("t2_full_v", 32'(ifb.link_v_o), 0);
    chk("t2_full_y", 32'(ifb.fifo_yumi_o), 0);
    cyc_b(1, 8'hC2, 1, 0);
    chk("t2_full_v2", 32'(ifb.link_v_o), 0);
    cyc_b(1, 8'hC2, 1, 1);
    chk("t2_ack_q", 32'(ifb.fifo_deq_o), 1);
    chk("t2_ack_v", 32'(ifb.link_v_o), 0);
    cyc_b(1, 8'hC2, 1, 0);
    chk("t2_o_after", 32'(out_b), 1);
    chk("t2_v3", 32'(ifb.link_v_o), 1);
    chk("t2_d3", 32'(ifb.link_data_o), 32'hC2);
    chk("t2_y3", 32'(ifb.fifo_yumi_o), 1);
    cyc_b(0, 8'h00, 1, 0);
    chk("t2_o_end", 32'(out_b), 2);
    chk("t2_err", 32'(err_b), 0);

`ifdef BSG_FIFO_ROLLY_REPLAY_CTRL_TIMEOUT_EN
    // Idle timeout: roll strobe appears the cycle after eight idle cycles
    cyc_a(0, 1, 8'hF0, 1, 0, 0);
    chk("t5_y", 32'(ifa.fifo_yumi_o), 1);
    for (int k = 1; k <= 8; k++) begin
      cyc_a(0, 0, 8'h00, 1, 0, 0);
      chk($sformatf("t5_idle%0d", k), 32'(ifa.fifo_roll_o), 0);
    end
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t5_roll", 32'(ifa.fifo_roll_o), 1);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t5_rc", 32'(rc_a), 1);
    chk("t5_out", 32'(out_a), 0);
    cyc_a(0, 1, 8'hF1, 1, 0, 0);
    for (int k = 1; k <= 7; k++) cyc_a(0, 0, 8'h00, 1, 0, 0);
    cyc_a(0, 0, 8'h00, 1, 1, 0);
    chk("t5_ack_deq", 32'(ifa.fifo_deq_o), 1);
    cyc_a(0, 0, 8'h00, 1, 0, 0);
    chk("t5_ack_roll", 32'(ifa.fifo_roll_o), 0);
    chk("t5_ack_rc", 32'(rc_a), 1);
    chk("t5_ack_out", 32'(out_a), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
